// File: rtl/alu_ctrl_muldiv_if.sv
// Execute-stage bundle between the pipeline and the ALU controller / RV32M unit.
// master drives the decode fields and operands; slave returns decode and M results.
interface alu_ctrl_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       ALUOp;
  logic             ImmOp;
  logic [2:0]       Funct3;
  logic [6:0]       Funct7;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       Operation;
  logic             is_muldiv;
  logic             illegal;
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output flush, in_valid, ALUOp, ImmOp, Funct3, Funct7, SrcA, SrcB,
    input  in_ready, Operation, is_muldiv, illegal, busy, out_valid, result
  );

  modport slave (
    input  flush, in_valid, ALUOp, ImmOp, Funct3, Funct7, SrcA, SrcB,
    output in_ready, Operation, is_muldiv, illegal, busy, out_valid, result
  );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// RV32 ALU operation decoder with an iterative RV32M unit (shift-add multiply,
// restoring divide), valid/ready handshake and pipeline stall output.
module alu_ctrl_muldiv #(
  parameter int WIDTH    = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  alu_ctrl_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SRA = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BLT = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1110;

  // Bit n set when the M op with Funct3=n treats that operand as signed.
  localparam logic [7:0] A_SIGNED = 8'h57;
  localparam logic [7:0] B_SIGNED = 8'h53;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [1:0]         op_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic [WIDTH-1:0]   b_mag_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   fix_reg;
  logic [WIDTH-1:0]   result_reg;

  // ---------------- decode ----------------
  logic [3:0] dec_op;
  logic       dec_ill;
  logic       dec_md;
  logic       f7_zero, f7_alt, f7_mul;

  always_comb begin
    f7_zero = (bus.Funct7 == 7'b0000000);
    f7_alt  = (bus.Funct7 == 7'b0100000);
    f7_mul  = (bus.Funct7 == 7'b0000001);
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    dec_md  = 1'b0;
    case (bus.ALUOp)
      2'b01: begin
        case (bus.Funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          default: dec_ill = 1'b1;
        endcase
      end
      2'b10: begin
        // I-type ignores Funct7 except for the shift encodings.
        if (bus.ImmOp || f7_zero) begin
          case (bus.Funct3)
            3'b000: dec_op = OP_ADD;
            3'b001: begin
              if (f7_zero) dec_op = OP_SLL;
              else         dec_ill = 1'b1;
            end
            3'b010: dec_op = OP_SLT;
            3'b011: dec_ill = 1'b1;
            3'b100: dec_op = OP_XOR;
            3'b101: begin
              if (f7_zero)     dec_op = OP_SRL;
              else if (f7_alt) dec_op = OP_SRA;
              else             dec_ill = 1'b1;
            end
            3'b110: dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (f7_alt) begin
          if (bus.Funct3 == 3'b000)      dec_op = OP_SUB;
          else if (bus.Funct3 == 3'b101) dec_op = OP_SRA;
          else                           dec_ill = 1'b1;
        end else if (f7_mul && ENABLE_M) begin
          dec_md = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_op = OP_ADD;
    endcase
    if (dec_ill) dec_op = OP_ADD;
  end

  assign bus.Operation = dec_op;
  assign bus.illegal   = dec_ill;
  assign bus.is_muldiv = dec_md;

  // ---------------- operand preparation ----------------
  logic             sign_a, sign_b, is_div, div_zero, div_ovf, fast, accept;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    is_div   = bus.Funct3[2];
    sign_a   = A_SIGNED[bus.Funct3] & bus.SrcA[WIDTH-1];
    sign_b   = B_SIGNED[bus.Funct3] & bus.SrcB[WIDTH-1];
    a_mag    = sign_a ? -bus.SrcA : bus.SrcA;
    b_mag    = sign_b ? -bus.SrcB : bus.SrcB;
    div_zero = is_div & (bus.SrcB == '0);
    div_ovf  = is_div & ~bus.Funct3[0] & (bus.SrcA == MIN_VAL) & (bus.SrcB == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = bus.Funct3[1] ? bus.SrcA : '1;
    else          fast_res = bus.Funct3[1] ? '0 : MIN_VAL;
    accept   = bus.in_valid & (state_reg == S_IDLE) & dec_md;
  end

  // ---------------- iteration step and sign fix ----------------
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, acc_next, prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix, mul_res, div_res, fix_val;

  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, b_mag_reg} : '0);
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
    // Upper half is the partial remainder, lower half shifts dividend out / quotient in.
    div_diff = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag_reg};
    div_next = div_diff[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    acc_next = (state_reg == S_MUL) ? mul_next : div_next;
    prod     = neg_q_reg ? -acc_next : acc_next;
    mul_res  = (op_reg == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    quo_fix  = neg_q_reg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem_fix  = neg_r_reg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    div_res  = op_reg[1] ? rem_fix : quo_fix;
    fix_val  = (state_reg == S_MUL) ? mul_res : div_res;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (fast)        state_next = S_DONE;
          else if (is_div) state_next = S_DIV;
          else             state_next = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (bus.flush)            state_next = S_IDLE;
        else if (cnt_reg == '0)   state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_reg == S_IDLE);
    bus.busy      = (state_reg == S_MUL) || (state_reg == S_DIV) ||
                    ((state_reg == S_IDLE) && bus.in_valid && dec_md);
    // A flush in DONE suppresses the pulse and leaves the visible result alone.
    bus.out_valid = (state_reg == S_DONE) && !bus.flush;
    bus.result    = bus.out_valid ? fix_reg : result_reg;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      op_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      b_mag_reg  <= '0;
      acc_reg    <= '0;
      fix_reg    <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        op_reg    <= bus.Funct3[1:0];
        neg_q_reg <= sign_a ^ sign_b;
        neg_r_reg <= sign_a;
        b_mag_reg <= b_mag;
        acc_reg   <= {{WIDTH{1'b0}}, a_mag};
        cnt_reg   <= CW'(WIDTH - 1);
        if (fast) fix_reg <= fast_res;
      end else if (((state_reg == S_MUL) || (state_reg == S_DIV)) && !bus.flush) begin
        acc_reg <= acc_next;
        if (cnt_reg == '0) fix_reg <= fix_val;
        else               cnt_reg <= cnt_reg - 1'b1;
      end
      if ((state_reg == S_DONE) && !bus.flush) result_reg <= fix_reg;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Randomised scoreboard bench for alu_ctrl_muldiv: decode against a rule model,
// M results and latency against 64-bit integer arithmetic.
module tb_alu_ctrl_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp = '0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          issue;
    int          done;
  } exp_t;
  exp_t q[$];

  alu_ctrl_muldiv_if #(.WIDTH(W)) bus ();
  alu_ctrl_muldiv_if #(.WIDTH(W)) bus0 ();

  alu_ctrl_muldiv #(.WIDTH(W), .ENABLE_M(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_ctrl_muldiv #(.WIDTH(W), .ENABLE_M(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  assign bus0.flush    = 1'b0;
  assign bus0.in_valid = bus.in_valid;
  assign bus0.ALUOp    = bus.ALUOp;
  assign bus0.ImmOp    = bus.ImmOp;
  assign bus0.Funct3   = bus.Funct3;
  assign bus0.Funct7   = bus.Funct7;
  assign bus0.SrcA     = bus.SrcA;
  assign bus0.SrcB     = bus.SrcB;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Decode reference: returns {is_muldiv, illegal, Operation}.
  function automatic logic [5:0] ref_dec(input logic [1:0] aluop, input logic imm,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input bit enm);
    logic [3:0] amap [8];
    logic [3:0] op;
    logic ill, md;
    amap = '{4'b0010, 4'b1001, 4'b0111, 4'b0010, 4'b0101, 4'b1101, 4'b0001, 4'b0000};
    op = 4'b0010; ill = 1'b0; md = 1'b0;
    if (aluop == 2'b01) begin
      case (f3)
        3'd0: op = 4'b1000;
        3'd1: op = 4'b1110;
        3'd4: op = 4'b1010;
        3'd5: op = 4'b1011;
        default: ill = 1'b1;
      endcase
    end else if (aluop == 2'b10) begin
      if (!imm && f7 == 7'h01) begin
        if (enm) md = 1'b1;
        else     ill = 1'b1;
      end else if (!imm && f7 == 7'h20) begin
        if (f3 == 3'd0)      op = 4'b0110;
        else if (f3 == 3'd5) op = 4'b0100;
        else                 ill = 1'b1;
      end else if (!imm && f7 != 7'h00) begin
        ill = 1'b1;
      end else begin
        op = amap[f3];
        if (f3 == 3'd3) ill = 1'b1;
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20)      op = 4'b0100;
          else if (f7 != 7'h00) ill = 1'b1;
        end
      end
    end
    if (ill) op = 4'b0010;
    return {md, ill, op};
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    p = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return W + 1;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic check_dec();
    logic [5:0] r1, r0;
    r1 = ref_dec(bus.ALUOp, bus.ImmOp, bus.Funct3, bus.Funct7, 1'b1);
    r0 = ref_dec(bus.ALUOp, bus.ImmOp, bus.Funct3, bus.Funct7, 1'b0);
    chk("is_muldiv", bus.is_muldiv, r1[5]);
    chk("illegal", bus.illegal, r1[4]);
    if (!r1[5]) chk("operation", bus.Operation, r1[3:0]);
    chk("m0_is_muldiv", bus0.is_muldiv, r0[5]);
    chk("m0_illegal", bus0.illegal, r0[4]);
    chk("m0_operation", bus0.Operation, r0[3:0]);
    chk("m0_busy", bus0.busy, 1'b0);
  endtask

  task automatic dec_lit(input logic imm, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] exp_op, input logic exp_ill);
    bus.ALUOp = 2'b10; bus.ImmOp = imm; bus.Funct3 = f3; bus.Funct7 = f7;
    #1;
    chk("dec_op", bus.Operation, exp_op);
    chk("dec_illegal", bus.illegal, exp_ill);
    @(posedge clk); #1;
  endtask

  task automatic issue_raw(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat, input bit push);
    int guard;
    exp_t e;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL in_ready_wait @cycle %0d: got in_ready=%b expected 1", cyc, bus.in_ready);
    end
    bus.ALUOp = 2'b10; bus.ImmOp = 1'b0; bus.Funct7 = 7'h01; bus.Funct3 = f3;
    bus.SrcA = a; bus.SrcB = b; bus.in_valid = 1'b1;
    #1;
    check_dec();
    if (push) begin
      e.f3 = f3; e.a = a; e.b = b; e.res = exp; e.issue = cyc; e.done = cyc + lat;
      q.push_back(e);
      last_exp = exp;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.ALUOp = 2'b00;
  endtask

  task automatic issue_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    issue_raw(f3, a, b, ref_m(f3, a, b), ref_lat(f3, a, b), 1'b1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (q.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain @cycle %0d: got %0d pending results expected 0", cyc, q.size());
      q.delete();
    end
  endtask

  // Monitor: handshake/stall shape while an op is in flight, result on out_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0) begin
        if (bus.out_valid) begin
          chk("out_cycle", cyc, q[0].done);
          chk("result", bus.result, q[0].res);
          chk("busy_done", bus.busy, 1'b0);
          chk("in_ready_done", bus.in_ready, 1'b0);
          $display("op f3=%0d a=%08h b=%08h result=%08h exp=%08h cycle=%0d",
                   q[0].f3, q[0].a, q[0].b, bus.result, q[0].res, cyc);
          void'(q.pop_front());
        end else if (cyc < q[0].done) begin
          chk("busy_run", bus.busy, 1'b1);
          chk("in_ready_run", bus.in_ready, (cyc == q[0].issue));
        end else begin
          if (cyc == q[0].done) begin
            checks++; failures++;
            $display("FAIL out_valid_late @cycle %0d: got out_valid=0 expected 1", cyc);
          end
          if (cyc > q[0].done + 64) void'(q.pop_front());
        end
      end else if (bus.out_valid) begin
        checks++; failures++;
        $display("FAIL unexpected_out_valid @cycle %0d: got result 0x%08h expected no pulse", cyc, bus.result);
      end
    end
  end

  initial begin
    int c0;
    logic [2:0] f3;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.ALUOp = 2'b00; bus.ImmOp = 1'b0;
    bus.Funct3 = 3'b000; bus.Funct7 = 7'h00; bus.SrcA = '0; bus.SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", bus.result, 32'h0);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    dec_lit(1'b1, 3'b000, 7'h20, 4'b0010, 1'b0);
    dec_lit(1'b0, 3'b000, 7'h20, 4'b0110, 1'b0);
    dec_lit(1'b0, 3'b000, 7'h03, 4'b0010, 1'b1);

    for (int i = 0; i < 200; i++) begin
      bus.ALUOp = 2'($urandom_range(0, 3));
      bus.ImmOp = 1'($urandom_range(0, 1));
      bus.Funct3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: bus.Funct7 = 7'h00;
        1: bus.Funct7 = 7'h20;
        2: bus.Funct7 = 7'h01;
        default: bus.Funct7 = 7'($urandom_range(0, 127));
      endcase
      #1;
      check_dec();
      @(posedge clk); #1;
    end

    issue_raw(3'b000, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 33, 1'b1);
    issue_raw(3'b011, 32'hFFFFFFFF, 32'd7, 32'h00000006, 33, 1'b1);
    issue_raw(3'b001, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 33, 1'b1);
    issue_raw(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b1);
    issue_raw(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b1);
    issue_raw(3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    issue_raw(3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    issue_raw(3'b100, 32'd100, 32'd0, 32'hFFFFFFFF, 1, 1'b1);
    issue_raw(3'b110, 32'd100, 32'd0, 32'd100, 1, 1'b1);
    issue_raw(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b1);
    issue_raw(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      issue_m(f3, rnd_opnd(), rnd_opnd());
    end
    wait_idle();

    // Flush on cycle 10 of a DIV.
    issue_raw(3'b100, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    c0 = cyc - 1;
    while (cyc < c0 + 10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1'b1);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_result", bus.result, last_exp);
    chk("flush_busy", bus.busy, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_result_hold", bus.result, last_exp);

    // Async reset on cycle 5 of a MUL.
    issue_m(3'b000, 32'd5, 32'd7);
    wait_idle();
    issue_raw(3'b000, 32'd12345, 32'd678, 32'd0, 0, 1'b0);
    c0 = cyc - 1;
    while (cyc < c0 + 5) begin @(posedge clk); #1; end
    #1;
    chk("pre_reset_result", bus.result, last_exp);
    rst_n = 1'b0;
    #1;
    chk("async_reset_result", bus.result, 32'h0);
    chk("async_reset_out_valid", bus.out_valid, 1'b0);
    chk("async_reset_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue_m(3'b011, 32'hDEADBEEF, 32'h12345678);
    issue_m(3'b010, 32'hFFFFFFFE, 32'h80000001);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
